// File: rtl/writeback_arbiter_if.sv
// Register-file write-port bundle: ALU/load result handshakes, issue scoreboard
// queries, same-cycle forwards and the registered write itself.
interface writeback_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  AluValid;
  logic                  AluReady;
  logic [ADDR_WIDTH-1:0] AluTarget;
  logic [DATA_WIDTH-1:0] AluData;
  logic                  LoadValid;
  logic                  LoadReady;
  logic [ADDR_WIDTH-1:0] LoadTarget;
  logic [DATA_WIDTH-1:0] LoadData;
  logic                  IssueValid;
  logic [ADDR_WIDTH-1:0] IssueTarget;
  logic [ADDR_WIDTH-1:0] ReadSourceA;
  logic [ADDR_WIDTH-1:0] ReadSourceB;
  logic                  PendingA;
  logic                  PendingB;
  logic                  ForwardValidA;
  logic                  ForwardValidB;
  logic [DATA_WIDTH-1:0] ForwardDataA;
  logic [DATA_WIDTH-1:0] ForwardDataB;
  logic                  WriteEnable;
  logic [ADDR_WIDTH-1:0] WriteTarget;
  logic [DATA_WIDTH-1:0] WriteData;

  modport master (
    output AluValid, AluTarget, AluData, LoadValid, LoadTarget, LoadData,
    output IssueValid, IssueTarget, ReadSourceA, ReadSourceB,
    input  AluReady, LoadReady, PendingA, PendingB,
    input  ForwardValidA, ForwardValidB, ForwardDataA, ForwardDataB,
    input  WriteEnable, WriteTarget, WriteData
  );

  modport slave (
    input  AluValid, AluTarget, AluData, LoadValid, LoadTarget, LoadData,
    input  IssueValid, IssueTarget, ReadSourceA, ReadSourceB,
    output AluReady, LoadReady, PendingA, PendingB,
    output ForwardValidA, ForwardValidB, ForwardDataA, ForwardDataB,
    output WriteEnable, WriteTarget, WriteData
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into one registered register-file write, with a
// pending-write scoreboard and a same-cycle forward of the write in flight.
module writeback_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  writeback_arbiter_if.slave   bus
);
  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  typedef enum logic {GRANT_ALU, GRANT_LOAD} grant_e;

  grant_e                last_grant, last_grant_next;
  logic                  write_enable_q;
  logic [ADDR_WIDTH-1:0] write_target_q;
  logic [DATA_WIDTH-1:0] write_data_q;
  logic [NUM_REGS-1:0]   pending_q, pending_next;

  logic                  alu_win, load_win;
  logic [ADDR_WIDTH-1:0] acc_target;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  write_enable_next;
  logic                  fwd_a, fwd_b;

  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      last_grant     <= GRANT_ALU;
      write_enable_q <= 1'b0;
      write_target_q <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
    end else begin
      last_grant     <= last_grant_next;
      write_enable_q <= write_enable_next;
      pending_q      <= pending_next;
      if (write_enable_next) begin
        write_target_q <= acc_target;
        write_data_q   <= acc_data;
      end
    end
  end

  always_comb begin
    alu_win           = bus.AluValid  && (!bus.LoadValid || last_grant == GRANT_LOAD);
    load_win          = bus.LoadValid && (!bus.AluValid  || last_grant == GRANT_ALU);
    last_grant_next   = last_grant;
    if (bus.AluValid && bus.LoadValid)
      last_grant_next = load_win ? GRANT_LOAD : GRANT_ALU;
    acc_target        = load_win ? bus.LoadTarget : bus.AluTarget;
    acc_data          = load_win ? bus.LoadData   : bus.AluData;
    // Writes to register 0 are consumed but never reach the file.
    write_enable_next = (alu_win || load_win) && (acc_target != '0);

    // Clear first so a same-edge issue to the committing register wins.
    pending_next = pending_q;
    if (write_enable_q)
      pending_next[write_target_q] = 1'b0;
    if (bus.IssueValid)
      pending_next[bus.IssueTarget] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    fwd_a = write_enable_q && (write_target_q == bus.ReadSourceA) && (bus.ReadSourceA != '0);
    fwd_b = write_enable_q && (write_target_q == bus.ReadSourceB) && (bus.ReadSourceB != '0);
  end

  assign bus.AluReady      = alu_win;
  assign bus.LoadReady     = load_win;
  assign bus.WriteEnable   = write_enable_q;
  assign bus.WriteTarget   = write_target_q;
  assign bus.WriteData     = write_data_q;
  assign bus.ForwardValidA = fwd_a;
  assign bus.ForwardValidB = fwd_b;
  assign bus.ForwardDataA  = fwd_a ? write_data_q : '0;
  assign bus.ForwardDataB  = fwd_b ? write_data_q : '0;
  assign bus.PendingA      = pending_q[bus.ReadSourceA] && !fwd_a;
  assign bus.PendingB      = pending_q[bus.ReadSourceB] && !fwd_b;
endmodule
